// File: rtl/sqrt_unit.sv
// rtl/sqrt_unit.sv - integer square root, restoring digit-by-digit, valid/ready handshakes
//
// Computes root_o = floor(sqrt(X)) and rem_o = X - root_o^2 for an unsigned
// WIDTH-bit operand. UNROLL root bits are resolved per CALC cycle, so the
// calculation takes NCYC = (WIDTH/2)/UNROLL cycles. An operand of zero skips
// CALC entirely and goes straight to DONE with a zero result.
//
// Ports:
//   clk_i        in   clock, all state on rising edge
//   rst_i        in   asynchronous active-high reset
//   in_valid_i   in   operand valid
//   in_ready_o   out  unit can accept an operand (IDLE only)
//   dt_i         in   operand X, unsigned, WIDTH bits
//   out_valid_o  out  result valid (DONE only)
//   out_ready_i  in   consumer accepts result
//   root_o       out  floor(sqrt(X)), WIDTH/2 bits
//   rem_o        out  X - root_o^2, WIDTH/2+1 bits
//   busy_o       out  high in CALC or DONE

module sqrt_unit #(
    parameter int WIDTH  = 16,
    parameter int UNROLL = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     dt_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [WIDTH/2-1:0]   root_o,
    output logic [WIDTH/2:0]     rem_o,
    output logic                 busy_o
);

    localparam int RW   = WIDTH / 2;
    localparam int NCYC = RW / UNROLL;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] x_q,     x_d;
    logic [RW-1:0]    root_q,  root_d;
    logic [RW+1:0]    rem_q,   rem_d;
    logic [CW-1:0]    cnt_q,   cnt_d;

    // Outcome of UNROLL chained restoring steps starting from the current regs.
    logic [WIDTH-1:0] x_w;
    logic [RW-1:0]    root_w;
    logic [RW+1:0]    rem_w;
    logic [RW+1:0]    r_try;
    logic [RW+1:0]    t_try;

    // The remainder never exceeds 2*root, so its top bit is always zero at
    // the output; it only exists to give the trial subtraction headroom.
    logic             unused_rem_msb;
    assign unused_rem_msb = rem_q[RW+1];

    always_comb begin
        x_w    = x_q;
        root_w = root_q;
        rem_w  = rem_q;
        r_try  = '0;
        t_try  = '0;
        for (int i = 0; i < UNROLL; i++) begin
            // Before any step the partial remainder is below 2^RW, so taking
            // its low RW bits and appending the next operand digit pair is a
            // lossless (rem << 2) | digits.
            r_try = {rem_w[RW-1:0], x_w[WIDTH-1:WIDTH-2]};
            t_try = {root_w, 2'b01};
            if (r_try >= t_try) begin
                rem_w  = r_try - t_try;
                root_w = {root_w[RW-2:0], 1'b1};
            end else begin
                rem_w  = r_try;
                root_w = {root_w[RW-2:0], 1'b0};
            end
            x_w = {x_w[WIDTH-3:0], 2'b00};
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        root_d  = root_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    x_d    = dt_i;
                    root_d = '0;
                    rem_d  = '0;
                    cnt_d  = CW'(NCYC - 1);
                    if (dt_i == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                x_d    = x_w;
                root_d = root_w;
                rem_d  = rem_w;
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            root_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            root_q  <= root_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready_o  = (state_q == ST_IDLE);
    assign out_valid_o = (state_q == ST_DONE);
    assign busy_o      = (state_q != ST_IDLE);
    assign root_o      = root_q;
    assign rem_o       = rem_q[RW:0];

endmodule

// File: tb/tb_sqrt_unit.sv
// tb/tb_sqrt_unit.sv - scoreboard bench for sqrt_unit at UNROLL 1, 2 and 8
module tb_sqrt_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic        busy      [3];
    logic [15:0] dt        [3];
    logic [7:0]  root      [3];
    logic [8:0]  rem       [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int UN = (g == 0) ? 1 : ((g == 1) ? 2 : 8);
        sqrt_unit #(.WIDTH(16), .UNROLL(UN)) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .in_valid_i  (in_valid[g]),
            .in_ready_o  (in_ready[g]),
            .dt_i        (dt[g]),
            .out_valid_o (out_valid[g]),
            .out_ready_i (out_ready[g]),
            .root_o      (root[g]),
            .rem_o       (rem[g]),
            .busy_o      (busy[g])
        );
    end

    typedef struct packed {
        logic [31:0] due;
        logic [7:0]  root;
        logic [8:0]  rem;
    } exp_t;

    exp_t exp_q [3][$];

    int checks   = 0;
    int failures = 0;
    int tmo      = 0;
    bit done     = 1'b0;
    bit rand_rdy = 1'b0;

    function automatic int ncyc(input int k);
        return (k == 0) ? 8 : ((k == 1) ? 4 : 1);
    endfunction

    // Reference: largest r with r*r <= x, found by plain search.
    function automatic void ref_sqrt(input int unsigned x, output int unsigned r, output int unsigned m);
        r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        m = x - r * r;
    endfunction

    task automatic chk(input string name, input int k, input longint unsigned act, input longint unsigned req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s[%0d] actual=%0d required=%0d at t=%0t", name, k, act, req, $time);
        end
    endtask

    // Monitor / scoreboard: samples on the falling edge.
    int          cyc = 0;
    logic        pend    [3];
    logic        hs_prev [3];
    logic [7:0]  hroot   [3];
    logic [8:0]  hrem    [3];

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                chk("reset_outputs", k,
                    longint'({in_ready[k], out_valid[k], busy[k], root[k], rem[k]}),
                    longint'({1'b1, 1'b0, 1'b0, 8'd0, 9'd0}));
                exp_q[k].delete();
                pend[k]    = 1'b0;
                hs_prev[k] = 1'b0;
            end else begin
                if (hs_prev[k])
                    chk("after_handshake", k, longint'({out_valid[k], in_ready[k]}), 2'b01);
                chk("busy_vs_ready", k, longint'(busy[k]), longint'(!in_ready[k]));
                if (pend[k]) begin
                    chk("hold_stable", k,
                        longint'({out_valid[k], in_ready[k], root[k], rem[k]}),
                        longint'({1'b1, 1'b0, hroot[k], hrem[k]}));
                end else if (out_valid[k]) begin
                    if (exp_q[k].size() == 0) begin
                        chk("unexpected_valid", k, 1, 0);
                    end else begin
                        exp_t e;
                        e = exp_q[k].pop_front();
                        chk("root", k, longint'(root[k]), longint'(e.root));
                        chk("rem", k, longint'(rem[k]), longint'(e.rem));
                        chk("latency", k, longint'(cyc), longint'(e.due));
                    end
                end
                if (in_valid[k] && in_ready[k]) begin
                    int unsigned r, m;
                    exp_t e;
                    ref_sqrt(int'(dt[k]), r, m);
                    e.root = 8'(r);
                    e.rem  = 9'(m);
                    e.due  = 32'(cyc + 1 + ((dt[k] == 16'd0) ? 0 : ncyc(k)));
                    exp_q[k].push_back(e);
                end
                pend[k]    = out_valid[k] && !out_ready[k];
                hs_prev[k] = out_valid[k] && out_ready[k];
                hroot[k]   = root[k];
                hrem[k]    = rem[k];
            end
        end
        if (done) begin
            chk("timeouts", 0, longint'(tmo), 0);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    // Driver: inputs change only 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy)
            for (int k = 0; k < 3; k++) out_ready[k] = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input int k, input logic [15:0] x, input bit keep);
        int n;
        dt[k]       = x;
        in_valid[k] = 1'b1;
        n = 0;
        while (!in_ready[k] && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready[k]) tmo++;
        tick();
        if (!keep) in_valid[k] = 1'b0;
        dt[k] = 16'($urandom);
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while (!(in_ready[k] && !out_valid[k] && exp_q[k].size() == 0) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) tmo++;
    endtask

    initial begin
        int n;
        logic [15:0] x;
        logic [7:0]  r8;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
            dt[k]        = 16'd0;
        end
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Directed values on the UNROLL=1 unit.
        send(0, 16'd0, 0);     wait_idle(0);
        send(0, 16'd1, 0);     wait_idle(0);
        send(0, 16'd144, 0);   wait_idle(0);
        send(0, 16'd255, 0);   wait_idle(0);
        send(0, 16'd65535, 0); wait_idle(0);

        // Backpressure with a competing operand held on the input.
        out_ready[0] = 1'b0;
        send(0, 16'd200, 0);
        n = 0;
        while (!out_valid[0] && n < 50) begin
            tick();
            n++;
        end
        if (!out_valid[0]) tmo++;
        in_valid[0] = 1'b1;
        dt[0]       = 16'd7;
        repeat (5) tick();
        out_ready[0] = 1'b1;
        send(0, 16'd7, 0);
        wait_idle(0);

        // Back-to-back with in_valid held high.
        send(0, 16'd100, 1);
        send(0, 16'd99, 0);
        wait_idle(0);

        // Reset in the middle of a calculation.
        send(0, 16'd1000, 0);
        repeat (4) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (12) tick();
        send(0, 16'd50, 0);
        wait_idle(0);

        // Randomized operands with random consumer stalls, all three unrolls.
        rand_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send(k, 16'd0, 0);
            send(k, 16'd65535, 0);
            for (int i = 0; i < 25; i++) begin
                r8 = 8'($urandom_range(1, 255));
                case ($urandom_range(0, 3))
                    0: x = 16'($urandom_range(0, 15));
                    1: x = 16'($urandom);
                    2: x = 16'(r8) * 16'(r8);
                    default: x = 16'(r8) * 16'(r8) - 16'd1;
                endcase
                send(k, x, (i != 24) && ($urandom_range(0, 1) == 1));
            end
            wait_idle(k);
        end
        rand_rdy = 1'b0;
        for (int k = 0; k < 3; k++) out_ready[k] = 1'b1;
        done = 1'b1;
        repeat (10) tick();
        $display("FAIL monitor_did_not_finish");
        $fatal(1, "bench stalled");
    end

endmodule
